conv2d_stream: RTL and testbench

CONV2D_STREAM -- requirements
Module: conv2d_stream

---
 rtl/conv2d_stream.sv | 173 +++++++++++++++++
 tb/tb_conv2d_stream.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv2d_stream.sv
// Streaming 2-D convolution over a raster-order image with line buffers and a registered
// single-result output stage; Q-format MAC with saturation and optional ReLU.
module conv2d_stream #(
  parameter int unsigned N   = 16,
  parameter int unsigned Q   = 12,
  parameter int unsigned W   = 8,
  parameter int unsigned H   = 8,
  parameter int unsigned K   = 3,
  parameter int unsigned S   = 1,
  parameter int unsigned CIN = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 relu_i,
  input  logic [K*K*CIN*N-1:0] weight_i,
  input  logic [N-1:0]         bias_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [CIN*N-1:0]     in_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [N-1:0]         out_data_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int unsigned PixW = CIN * N;
  localparam int unsigned AccW = 2 * N + $clog2(K * K * CIN) + 1;
  localparam int unsigned ColW = (W > 1) ? $clog2(W) : 1;
  localparam int unsigned RowW = (H > 1) ? $clog2(H) : 1;
  localparam logic signed [AccW-1:0] MaxV = {{(AccW-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [AccW-1:0] MinV = {{(AccW-N+1){1'b1}}, {(N-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e                 state_q, state_d;
  logic [ColW-1:0]        col_q, col_d;
  logic [RowW-1:0]        row_q, row_d;
  logic [K*K*CIN*N-1:0]   weight_q;
  logic [N-1:0]           bias_q;
  logic                   relu_q;
  logic                   out_valid_q, out_valid_d;
  logic [N-1:0]           out_data_q, out_data_d;
  // lb_q[0] is the oldest buffered row; wcol_q[0] the oldest window column.
  logic [PixW-1:0]        lb_q   [K-1][W];
  logic [PixW-1:0]        wcol_q [K-1][K];
  logic [PixW-1:0]        cur_col [K];
  logic                   accept, last_pix, emit;
  logic signed [AccW-1:0] acc, shifted;
  logic [N-1:0]           result;

  always_comb begin
    for (int ky = 0; ky < K - 1; ky++) cur_col[ky] = lb_q[ky][col_q];
    cur_col[K-1] = in_data_i;
  end

  always_comb begin
    logic signed [N-1:0]   a_s, b_s, bias_s;
    logic signed [2*N-1:0] prod;
    logic [PixW-1:0]       pix;
    bias_s = bias_q;
    acc    = AccW'(bias_s) <<< Q;
    for (int ch = 0; ch < CIN; ch++) begin
      for (int ky = 0; ky < K; ky++) begin
        for (int kx = 0; kx < K; kx++) begin
          pix  = (kx == K - 1) ? cur_col[ky] : wcol_q[kx][ky];
          a_s  = pix[ch*N +: N];
          b_s  = weight_q[((ch*K+ky)*K+kx)*N +: N];
          prod = a_s * b_s;
          acc  = acc + AccW'(prod);
        end
      end
    end
    shifted = acc >>> Q;
    if (shifted > MaxV)      result = {1'b0, {(N-1){1'b1}}};
    else if (shifted < MinV) result = {1'b1, {(N-1){1'b0}}};
    else                     result = shifted[N-1:0];
    if (relu_q && result[N-1]) result = '0;
  end

  always_comb begin
    emit = 1'b0;
    if (int'(row_q) >= int'(K - 1) && int'(col_q) >= int'(K - 1)) begin
      emit = ((int'(row_q) - int'(K - 1)) % int'(S) == 0) &&
             ((int'(col_q) - int'(K - 1)) % int'(S) == 0);
    end
  end

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    in_ready_o  = (state_q == StRun) && (!out_valid_q || out_ready_i);
    accept      = in_valid_i && in_ready_o;
    last_pix    = (row_q == RowW'(H - 1)) && (col_q == ColW'(W - 1));
    case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StRun;
          col_d   = '0;
          row_d   = '0;
        end
      end
      StRun: begin
        if (accept) begin
          if (col_q == ColW'(W - 1)) begin
            col_d = '0;
            row_d = row_q + RowW'(1);
          end else begin
            col_d = col_q + ColW'(1);
          end
          if (last_pix) state_d = StDrain;
        end
      end
      StDrain: if (!out_valid_q || out_ready_i) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (out_valid_q && out_ready_i) out_valid_d = 1'b0;
    // Acceptance implies the output slot is free or draining this cycle.
    if (accept && emit) begin
      out_valid_d = 1'b1;
      out_data_d  = result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      col_q       <= '0;
      row_q       <= '0;
      weight_q    <= '0;
      bias_q      <= '0;
      relu_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      for (int ky = 0; ky < K - 1; ky++) begin
        for (int x = 0; x < W; x++) lb_q[ky][x] <= '0;
      end
      for (int kx = 0; kx < K - 1; kx++) begin
        for (int ky = 0; ky < K; ky++) wcol_q[kx][ky] <= '0;
      end
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      if (state_q == StIdle && start_i) begin
        weight_q <= weight_i;
        bias_q   <= bias_i;
        relu_q   <= relu_i;
      end
      if (accept) begin
        for (int ky = 0; ky < K - 2; ky++) lb_q[ky][col_q] <= lb_q[ky+1][col_q];
        lb_q[K-2][col_q] <= in_data_i;
        for (int kx = 0; kx < K - 2; kx++) begin
          for (int ky = 0; ky < K; ky++) wcol_q[kx][ky] <= wcol_q[kx+1][ky];
        end
        for (int ky = 0; ky < K; ky++) wcol_q[K-2][ky] <= cur_col[ky];
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign busy_o      = (state_q == StRun) || (state_q == StDrain);
  assign done_o      = (state_q == StDone);

endmodule

// File: tb/tb_conv2d_stream.sv
// Directed bench for conv2d_stream: a 6x6 two-channel instance (single-channel cases use zero
// channel-1 weights) and a 7x7 stride-2 instance exercised with and without output stalls.
module tb_conv2d_stream;

  logic clk, rst, relu, out_ready, stall_en;
  logic [15:0] bias;
  logic start_a, in_valid_a, in_ready_a, out_valid_a, busy_a, done_a;
  logic [287:0] weight_a;
  logic [31:0] in_data_a;
  logic [15:0] out_data_a;
  logic start_b, in_valid_b, in_ready_b, out_valid_b, busy_b, done_b;
  logic [143:0] weight_b;
  logic [15:0] in_data_b, out_data_b;

  int n_checks, n_fail, done_cnt_a, done_cnt_b, hold_viol;
  logic [15:0] got_a[$];
  logic [15:0] got_b[$];
  logic b_stalled;
  logic [15:0] b_held;

  conv2d_stream #(.N(16), .Q(12), .W(6), .H(6), .K(3), .S(1), .CIN(2)) u_a (
    .clk(clk), .rst(rst), .start_i(start_a), .relu_i(relu), .weight_i(weight_a),
    .bias_i(bias), .in_valid_i(in_valid_a), .in_ready_o(in_ready_a), .in_data_i(in_data_a),
    .out_valid_o(out_valid_a), .out_ready_i(out_ready), .out_data_o(out_data_a),
    .busy_o(busy_a), .done_o(done_a)
  );

  conv2d_stream #(.N(16), .Q(12), .W(7), .H(7), .K(3), .S(2), .CIN(1)) u_b (
    .clk(clk), .rst(rst), .start_i(start_b), .relu_i(relu), .weight_i(weight_b),
    .bias_i(bias), .in_valid_i(in_valid_b), .in_ready_o(in_ready_b), .in_data_i(in_data_b),
    .out_valid_o(out_valid_b), .out_ready_i(out_ready), .out_data_o(out_data_b),
    .busy_o(busy_b), .done_o(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // Handshakes are judged at the negedge: what is seen here transfers at the next posedge.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid_a && out_ready) got_a.push_back(out_data_a);
      if (out_valid_b && out_ready) got_b.push_back(out_data_b);
      if (done_a) done_cnt_a++;
      if (done_b) done_cnt_b++;
      if (b_stalled && (!out_valid_b || out_data_b !== b_held)) hold_viol++;
      if (out_valid_b && !out_ready && in_ready_b) hold_viol++;
      b_stalled = out_valid_b && !out_ready;
      b_held    = out_data_b;
    end else begin
      b_stalled = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [15:0] model_b(input int idx);
    longint acc;
    logic signed [15:0] px;
    int r0, c0;
    acc = 0;
    r0  = (idx / 3) * 2;
    c0  = (idx % 3) * 2;
    for (int ky = 0; ky < 3; ky++) begin
      for (int kx = 0; kx < 3; kx++) begin
        px  = 16'(((r0 + ky) * 7 + (c0 + kx)) << 12);
        acc = acc + longint'(px) * 512;
      end
    end
    acc = acc >>> 12;
    if (acc > 32767) return 16'h7fff;
    if (acc < -32768) return 16'h8000;
    return 16'(acc);
  endfunction

  task automatic drive(input bit sel_b, input int n, input logic [15:0] a0, input logic [15:0] a1,
                       input bit perturb);
    bit acc;
    int t;
    for (int p = 0; p < n; p++) begin
      if (sel_b) begin
        in_valid_b = 1'b1;
        in_data_b  = 16'(p << 12);
      end else begin
        in_valid_a = 1'b1;
        in_data_a  = {a1, a0};
        if (perturb) start_a = (p == 10);
      end
      acc = 1'b0;
      t   = 0;
      while (!acc && t < 200) begin
        @(negedge clk);
        acc = sel_b ? in_ready_b : in_ready_a;
        @(posedge clk);
        #1;
        t++;
      end
      if (!acc) begin
        check("drive_accept", {31'd0, acc}, 32'd1);
        break;
      end
    end
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    start_a    = 1'b0;
  endtask

  task automatic wait_done(input bit sel_b, input string tag);
    int t;
    t = 0;
    while (((sel_b ? done_cnt_b : done_cnt_a) == 0) && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    check({tag, "_done_seen"}, ((sel_b ? done_cnt_b : done_cnt_a) != 0), 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic start_img_a(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] b,
                             input logic r);
    got_a.delete();
    done_cnt_a = 0;
    for (int i = 0; i < 9; i++) begin
      weight_a[i*16 +: 16]     = w0;
      weight_a[(9+i)*16 +: 16] = w1;
    end
    bias    = b;
    relu    = r;
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
  endtask

  task automatic image_a(input string tag, input logic [15:0] a0, input logic [15:0] a1,
                         input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] b,
                         input logic r, input logic [15:0] exp, input bit perturb);
    start_img_a(w0, w1, b, r);
    check({tag, "_busy"}, busy_a, 1);
    if (perturb) begin
      weight_a = '1;
      bias     = 16'h7fff;
      relu     = ~r;
    end
    drive(1'b0, 36, a0, a1, perturb);
    wait_done(1'b0, tag);
    check({tag, "_count"}, got_a.size(), 16);
    for (int i = 0; i < got_a.size(); i++) check({tag, "_data"}, got_a[i], exp);
    check({tag, "_done_once"}, done_cnt_a, 1);
    check({tag, "_idle"}, busy_a, 0);
  endtask

  task automatic image_b(input string tag, input bit stall);
    got_b.delete();
    done_cnt_b = 0;
    hold_viol  = 0;
    for (int i = 0; i < 9; i++) weight_b[i*16 +: 16] = 16'h0200;
    bias     = 16'h0000;
    relu     = 1'b0;
    stall_en = stall;
    start_b  = 1'b1;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    drive(1'b1, 49, 16'h0, 16'h0, 1'b0);
    wait_done(1'b1, tag);
    stall_en = 1'b0;
    check({tag, "_count"}, got_b.size(), 9);
    for (int i = 0; i < got_b.size(); i++) check({tag, "_data"}, got_b[i], model_b(i));
    check({tag, "_done_once"}, done_cnt_b, 1);
    check({tag, "_hold"}, hold_viol, 0);
  endtask

  initial begin
    n_checks = 0; n_fail = 0; done_cnt_a = 0; done_cnt_b = 0; hold_viol = 0;
    rst = 1'b1; relu = 1'b0; bias = '0; stall_en = 1'b0; b_stalled = 1'b0; b_held = '0;
    start_a = 1'b0; in_valid_a = 1'b0; in_data_a = '0; weight_a = '0;
    start_b = 1'b0; in_valid_b = 1'b0; in_data_b = '0; weight_b = '0;
    do_reset();

    check("rst_a_valid", out_valid_a, 0);
    check("rst_a_ready", in_ready_a, 0);
    check("rst_a_busy", busy_a, 0);
    check("rst_a_done", done_a, 0);
    check("rst_a_data", out_data_a, 0);
    check("rst_b_valid", out_valid_b, 0);
    check("rst_b_ready", in_ready_b, 0);
    check("rst_b_busy", busy_b, 0);
    check("rst_b_data", out_data_b, 0);

    in_valid_a = 1'b1;
    in_data_a  = 32'h1000_1000;
    repeat (4) @(posedge clk);
    #1;
    check("idle_ready", in_ready_a, 0);
    check("idle_no_out", got_a.size(), 0);
    in_valid_a = 1'b0;

    image_a("basic", 16'h1000, 16'h0000, 16'h0200, 16'h0000, 16'h0000, 1'b0, 16'h1200, 1'b0);
    image_a("two_ch", 16'h1000, 16'h1000, 16'h0200, 16'h0200, 16'h0400, 1'b0, 16'h2800, 1'b0);
    image_a("sat_pos", 16'h1000, 16'h0000, 16'h1000, 16'h0000, 16'h0000, 1'b0, 16'h7fff, 1'b0);
    image_a("sat_neg", 16'h1000, 16'h0000, 16'hf000, 16'h0000, 16'h0000, 1'b0, 16'h8000, 1'b0);
    image_a("neg_latch", 16'h1000, 16'h0000, 16'hfe00, 16'h0000, 16'h0000, 1'b0, 16'hee00, 1'b1);
    image_a("relu", 16'h1000, 16'h0000, 16'hfe00, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0);

    // Abort an image part-way and confirm the restart is clean.
    start_img_a(16'h1000, 16'h1000, 16'h7000, 1'b0);
    drive(1'b0, 20, 16'h7fff, 16'h7fff, 1'b0);
    do_reset();
    repeat (5) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt_a, 0);
    check("abort_busy", busy_a, 0);
    check("abort_valid", out_valid_a, 0);
    image_a("restart", 16'h1000, 16'h0000, 16'h0200, 16'h0000, 16'h0000, 1'b0, 16'h1200, 1'b0);

    image_b("s2", 1'b0);
    image_b("s2_stall", 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
